// File: rtl/arm_shift_pipe.sv
// Pipelined ARM barrel shifter: LSL/LSR/ASR/ROR with ARM carry-out, immediate and
// register amounts, shift ranks split across STAGES valid/ready register stages.
module arm_shift_pipe #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned AMOUNT_WIDTH = 8,
  parameter int unsigned STAGES       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    imm_mode,
  input  logic [1:0]              shift_op,
  input  logic [DATA_WIDTH-1:0]   shift_in,
  input  logic [AMOUNT_WIDTH-1:0] shift_amount,
  input  logic                    carry_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   shift_out,
  output logic                    carry_out
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned L    = $clog2(DATA_WIDTH);
  localparam int unsigned HW   = AMOUNT_WIDTH - L;
  localparam int unsigned BASE = L / STAGES;
  localparam int unsigned REM  = L % STAGES;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

  logic stall;

  // Stage-input bundle: W+1 bit vector (data plus carry slot) and shift control.
  logic [W:0]   st_v     [STAGES];
  logic [L-1:0] st_s     [STAGES];
  logic         st_left  [STAGES];
  logic         st_rot   [STAGES];
  logic         st_fill  [STAGES];
  logic         st_valid [STAGES];

  logic [W:0]    d_v;
  logic [L-1:0]  d_s;
  logic          d_left;
  logic          d_rot;
  logic          d_fill;
  logic          d_norm;
  logic [L-1:0]  amt_lo;
  logic [HW-1:0] amt_hi;
  logic          amt_big;
  logic          amt_eq_w;
  logic          msb;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  assign amt_lo   = shift_amount[L-1:0];
  assign amt_hi   = shift_amount[AMOUNT_WIDTH-1:L];
  assign amt_big  = |amt_hi;
  assign amt_eq_w = (amt_hi == HW'(1)) && (amt_lo == '0);
  assign msb      = shift_in[W-1];

  // Left mode keeps the last bit shifted out in v[W]; right modes keep it in v[0].
  // Special cases are folded into a zero-amount vector whose extraction yields the answer.
  always_comb begin
    d_v    = {carry_in, shift_in};
    d_s    = '0;
    d_left = 1'b1;
    d_rot  = 1'b0;
    d_fill = 1'b0;
    d_norm = 1'b0;
    if (imm_mode) begin
      if (amt_lo == '0) begin
        case (shift_op)
          OP_LSL:  d_v = {carry_in, shift_in};
          OP_LSR:  d_v = {msb, {W{1'b0}}};
          OP_ASR:  d_v = {(W+1){msb}};
          default: d_left = 1'b0;  // RRX: {carry_in, in} read out as a right shift by 0
        endcase
      end else begin
        d_norm = 1'b1;
      end
    end else if (shift_amount == '0) begin
      d_v = {carry_in, shift_in};
    end else if (amt_big) begin
      case (shift_op)
        OP_LSL:  d_v = {amt_eq_w & shift_in[0], {W{1'b0}}};
        OP_LSR:  d_v = {amt_eq_w & msb, {W{1'b0}}};
        OP_ASR:  d_v = {(W+1){msb}};
        default: begin
          if (amt_lo == '0) d_v = {msb, shift_in};
          else              d_norm = 1'b1;
        end
      endcase
    end else begin
      d_norm = 1'b1;
    end

    if (d_norm) begin
      d_s    = amt_lo;
      d_left = (shift_op == OP_LSL);
      d_rot  = (shift_op == 2'b11);
      d_fill = (shift_op == OP_ASR) & msb;
      if (shift_op != OP_LSL) d_v = {shift_in, carry_in};
    end
  end

  assign st_v[0]     = d_v;
  assign st_s[0]     = d_s;
  assign st_left[0]  = d_left;
  assign st_rot[0]   = d_rot;
  assign st_fill[0]  = d_fill;
  assign st_valid[0] = in_valid & in_ready;

  // One shift rank of 'sh' positions; rotation acts on the data bits only.
  function automatic logic [W:0] rank(input logic [W:0] v, input int unsigned sh,
                                      input logic left, input logic rot, input logic fill);
    if (left)     return v << sh;
    else if (rot) return {W'({v[W:1], v[W:1]} >> sh), v[0]};
    else          return (W+1)'({{(W+1){fill}}, v} >> sh);
  endfunction

  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    localparam int unsigned LO = j * BASE + ((j < REM) ? j : REM);
    localparam int unsigned HI = LO + BASE + ((j < REM) ? 1 : 0);

    logic [W:0] pv;

    always_comb begin
      pv = st_v[j];
      for (int unsigned k = LO; k < HI; k++) begin
        if (st_s[j][k]) pv = rank(pv, 32'd1 << k, st_left[j], st_rot[j], st_fill[j]);
      end
    end

    if (j < STAGES - 1) begin : g_mid
      logic [W:0]   v_q;
      logic [L-1:0] s_q;
      logic         left_q;
      logic         rot_q;
      logic         fill_q;
      logic         valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q     <= '0;
          s_q     <= '0;
          left_q  <= 1'b1;
          rot_q   <= 1'b0;
          fill_q  <= 1'b0;
          valid_q <= 1'b0;
        end else if (!stall) begin
          v_q     <= pv;
          s_q     <= st_s[j];
          left_q  <= st_left[j];
          rot_q   <= st_rot[j];
          fill_q  <= st_fill[j];
          valid_q <= st_valid[j];
        end
      end

      assign st_v[j+1]     = v_q;
      assign st_s[j+1]     = s_q;
      assign st_left[j+1]  = left_q;
      assign st_rot[j+1]   = rot_q;
      assign st_fill[j+1]  = fill_q;
      assign st_valid[j+1] = valid_q;
    end else begin : g_last
      // Output register: result and carry extracted from the final vector.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          shift_out <= '0;
          carry_out <= 1'b0;
        end else if (!stall) begin
          out_valid <= st_valid[j];
          if (st_valid[j]) begin
            shift_out <= st_left[j] ? pv[W-1:0] : pv[W:1];
            carry_out <= (st_left[j] | st_rot[j]) ? pv[W] : pv[0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_arm_shift_pipe.sv
// Directed and random checks of arm_shift_pipe at three width/depth points against
// hand-computed values and a behavioural ARM shifter model.
module tb_arm_shift_pipe;

  localparam int unsigned NDUT = 3;
  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;
  localparam logic [63:0] XDIR = {32'h7FFF_FFFE, 32'h8000_0001};

  typedef struct {
    logic [63:0] r;
    logic        c;
    int          t;
    bit          lat;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        imm_mode;
  logic [1:0]  shift_op;
  logic [63:0] x_in;
  logic [7:0]  shift_amount;
  logic        carry_in;
  logic        out_ready;

  logic        ir32, ov32, co32;
  logic [31:0] so32;
  logic        ir8, ov8, co8;
  logic [7:0]  so8;
  logic        ir64, ov64, co64;
  logic [63:0] so64;

  logic        ir [NDUT];
  logic        ov [NDUT];
  logic        co [NDUT];
  logic [63:0] so [NDUT];

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        q [NDUT][$];
  logic [63:0] hold_so [NDUT];
  logic        hold_co [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arm_shift_pipe #(.DATA_WIDTH(32), .AMOUNT_WIDTH(8), .STAGES(2)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32), .imm_mode(imm_mode),
    .shift_op(shift_op), .shift_in(x_in[31:0]), .shift_amount(shift_amount),
    .carry_in(carry_in), .out_valid(ov32), .out_ready(out_ready), .shift_out(so32),
    .carry_out(co32));

  arm_shift_pipe #(.DATA_WIDTH(8), .AMOUNT_WIDTH(8), .STAGES(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .imm_mode(imm_mode),
    .shift_op(shift_op), .shift_in(x_in[7:0]), .shift_amount(shift_amount),
    .carry_in(carry_in), .out_valid(ov8), .out_ready(out_ready), .shift_out(so8),
    .carry_out(co8));

  arm_shift_pipe #(.DATA_WIDTH(64), .AMOUNT_WIDTH(8), .STAGES(1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64), .imm_mode(imm_mode),
    .shift_op(shift_op), .shift_in(x_in), .shift_amount(shift_amount),
    .carry_in(carry_in), .out_valid(ov64), .out_ready(out_ready), .shift_out(so64),
    .carry_out(co64));

  always_comb begin
    ir[0] = ir32; ov[0] = ov32; co[0] = co32; so[0] = {32'd0, so32};
    ir[1] = ir8;  ov[1] = ov8;  co[1] = co8;  so[1] = {56'd0, so8};
    ir[2] = ir64; ov[2] = ov64; co[2] = co64; so[2] = so64;
  end

  function automatic int unsigned wd(input int d);
    return (d == 0) ? 32 : (d == 1) ? 8 : 64;
  endfunction

  function automatic int unsigned stg(input int d);
    return (d == 0) ? 2 : (d == 1) ? 3 : 1;
  endfunction

  // Behavioural reference: returns {carry, result}.
  function automatic logic [64:0] ref_shift(input int unsigned w, input logic imm,
                                            input logic [1:0] op, input logic [63:0] xin,
                                            input int unsigned amt, input logic cin);
    logic [63:0] mask, x, r;
    logic c, msb;
    int unsigned a, n;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x    = xin & mask;
    msb  = x[w-1];
    a    = amt % w;
    n    = imm ? a : amt;
    r    = '0;
    c    = cin;
    if (imm && a == 0) begin
      case (op)
        2'd0:    begin r = x;  c = cin; end
        2'd1:    begin r = '0; c = msb; end
        2'd2:    begin r = msb ? mask : '0; c = msb; end
        default: begin r = (x >> 1) | (64'(cin) << (w - 1)); c = x[0]; end
      endcase
    end else if (n == 0) begin
      r = x; c = cin;
    end else begin
      case (op)
        2'd0: if (n < w) begin r = (x << n) & mask; c = x[w-n]; end
              else begin r = '0; c = (n == w) ? x[0] : 1'b0; end
        2'd1: if (n < w) begin r = x >> n; c = x[n-1]; end
              else begin r = '0; c = (n == w) ? msb : 1'b0; end
        2'd2: if (n < w) begin r = (x >> n) | (msb ? (mask & ~(mask >> n)) : '0); c = x[n-1]; end
              else begin r = msb ? mask : '0; c = msb; end
        default: if (a == 0) begin r = x; c = msb; end
                 else begin r = ((x >> a) | (x << (w - a))) & mask; c = r[w-1]; end
      endcase
    end
    return {c, r};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, retire/accept at negedge+1.
  task automatic cycle(input bit iv, input bit imm, input logic [1:0] op, input logic [63:0] x,
                       input logic [7:0] amt, input bit cin, input bit ordy, input bit use_hand,
                       input logic [32:0] hand, input string tag, input bit lat);
    exp_t e;
    logic [64:0] m;
    @(negedge clk);
    in_valid = iv; imm_mode = imm; shift_op = op; x_in = x;
    shift_amount = amt; carry_in = cin; out_ready = ordy;
    #1;
    for (int d = 0; d < int'(NDUT); d++) begin
      if (ov[d] && out_ready) begin
        if (q[d].size() == 0) begin
          check($sformatf("spurious_d%0d", d), 64'(ov[d]), 64'd0);
        end else begin
          e = q[d].pop_front();
          check($sformatf("%s_d%0d_data", e.tag, d), so[d], e.r);
          check($sformatf("%s_d%0d_carry", e.tag, d), 64'(co[d]), 64'(e.c));
          if (e.lat) check($sformatf("%s_d%0d_latency", e.tag, d), 64'(cyc - e.t), 64'(stg(d)));
        end
      end
      if (in_valid && ir[d]) begin
        m = ref_shift(wd(d), imm, op, x, int'(amt), cin);
        if (d == 0 && use_hand) begin
          e.r = {32'd0, hand[31:0]};
          e.c = hand[32];
        end else begin
          e.r = m[63:0];
          e.c = m[64];
        end
        e.t = cyc; e.lat = lat; e.tag = tag;
        q[d].push_back(e);
      end
    end
  endtask

  task automatic dir(input bit imm, input logic [1:0] op, input logic [7:0] amt, input bit cin,
                     input logic [31:0] r, input bit c, input string tag);
    cycle(1'b1, imm, op, XDIR, amt, cin, 1'b1, 1'b1, {c, r}, tag, 1'b1);
  endtask

  task automatic rand_op(input bit ordy, input string tag, input bit lat);
    logic [7:0] amt;
    case ($urandom_range(0, 3))
      0:       amt = 8'($urandom_range(0, 7));
      1:       amt = 8'($urandom_range(0, 63));
      2:       amt = 8'($urandom_range(0, 255));
      default: amt = 8'(8 << $urandom_range(0, 3));
    endcase
    cycle(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), {$urandom, $urandom},
          amt, 1'($urandom_range(0, 1)), ordy, 1'b0, '0, tag, lat);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q[0].size() + q[1].size() + q[2].size()) != 0; i++)
      cycle(1'b0, 1'b0, SH_LSL, '0, '0, 1'b0, 1'b1, 1'b0, '0, "idle", 1'b1);
    for (int d = 0; d < int'(NDUT); d++)
      check($sformatf("drain_d%0d", d), 64'(q[d].size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; imm_mode = 1'b0; shift_op = SH_LSL; x_in = '0;
    shift_amount = '0; carry_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < int'(NDUT); d++) begin
      check($sformatf("reset_valid_d%0d", d), 64'(ov[d]), 64'd0);
      check($sformatf("reset_data_d%0d", d), so[d], 64'd0);
      check($sformatf("reset_carry_d%0d", d), 64'(co[d]), 64'd0);
      check($sformatf("reset_ready_d%0d", d), 64'(ir[d]), 64'd1);
    end
    rst_n = 1'b1;

    // Immediate-mode encodings, in = 0x8000_0001
    dir(1'b1, SH_LSR, 8'd0,    1'b0, 32'h0000_0000, 1'b1, "imm_lsr0");
    dir(1'b1, SH_ASR, 8'd0,    1'b0, 32'hFFFF_FFFF, 1'b1, "imm_asr0");
    dir(1'b1, SH_ROR, 8'd0,    1'b0, 32'h4000_0000, 1'b1, "imm_rrx");
    dir(1'b1, SH_LSL, 8'd0,    1'b0, 32'h8000_0001, 1'b0, "imm_lsl0");
    dir(1'b1, SH_ROR, 8'd0,    1'b1, 32'hC000_0000, 1'b1, "imm_rrx_c1");
    dir(1'b1, SH_LSR, 8'h20,   1'b0, 32'h0000_0000, 1'b1, "imm_lsr_hi_ignored");
    dir(1'b1, SH_LSR, 8'd4,    1'b0, 32'h0800_0000, 1'b0, "imm_lsr4");
    dir(1'b1, SH_ASR, 8'd1,    1'b0, 32'hC000_0000, 1'b1, "imm_asr1");
    // Register-mode amounts including >= W
    dir(1'b0, SH_LSL, 8'd32,   1'b0, 32'h0000_0000, 1'b1, "reg_lsl32");
    dir(1'b0, SH_LSL, 8'd33,   1'b0, 32'h0000_0000, 1'b0, "reg_lsl33");
    dir(1'b0, SH_LSR, 8'd200,  1'b0, 32'h0000_0000, 1'b0, "reg_lsr200");
    dir(1'b0, SH_LSR, 8'd32,   1'b0, 32'h0000_0000, 1'b1, "reg_lsr32");
    dir(1'b0, SH_ASR, 8'd255,  1'b0, 32'hFFFF_FFFF, 1'b1, "reg_asr255");
    dir(1'b0, SH_ROR, 8'd64,   1'b0, 32'h8000_0001, 1'b1, "reg_ror64");
    dir(1'b0, SH_ROR, 8'd36,   1'b0, 32'h1800_0000, 1'b0, "reg_ror36");
    dir(1'b0, SH_LSL, 8'd0,    1'b1, 32'h8000_0001, 1'b1, "reg_lsl0_c1");
    dir(1'b0, SH_LSL, 8'd1,    1'b0, 32'h0000_0002, 1'b1, "reg_lsl1");
    dir(1'b0, SH_LSR, 8'd31,   1'b0, 32'h0000_0001, 1'b0, "reg_lsr31");
    dir(1'b0, SH_ASR, 8'd4,    1'b0, 32'hF800_0000, 1'b0, "reg_asr4");
    dir(1'b0, SH_ROR, 8'd1,    1'b0, 32'hC000_0000, 1'b1, "reg_ror1");
    drain();

    // Back-to-back random operations
    for (int i = 0; i < 16; i++) rand_op(1'b1, "rand", 1'b1);
    drain();

    // Backpressure with a full pipe
    for (int i = 0; i < 4; i++) rand_op(1'b1, "bp", 1'b0);
    for (int i = 0; i < 5; i++) begin
      rand_op(1'b0, "bp_blocked", 1'b0);
      for (int d = 0; d < int'(NDUT); d++) begin
        check($sformatf("bp_in_ready_d%0d", d), 64'(ir[d]), 64'd0);
        check($sformatf("bp_out_valid_d%0d", d), 64'(ov[d]), 64'd1);
        if (i == 0) begin
          hold_so[d] = so[d];
          hold_co[d] = co[d];
        end else begin
          check($sformatf("bp_hold_data_d%0d", d), so[d], hold_so[d]);
          check($sformatf("bp_hold_carry_d%0d", d), 64'(co[d]), 64'(hold_co[d]));
        end
      end
    end
    for (int i = 0; i < 4; i++) rand_op(1'b1, "bp_after", 1'b0);
    drain();

    // Reset with operations in flight
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, SH_LSL, XDIR, 8'd1, 1'b0, 1'b0, 1'b0, '0, "rst_load", 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < int'(NDUT); d++) begin
      check($sformatf("midrst_valid_d%0d", d), 64'(ov[d]), 64'd0);
      check($sformatf("midrst_data_d%0d", d), so[d], 64'd0);
      check($sformatf("midrst_carry_d%0d", d), 64'(co[d]), 64'd0);
      q[d].delete();
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, SH_LSL, '0, '0, 1'b0, 1'b1, 1'b0, '0, "post_rst", 1'b1);
      for (int d = 0; d < int'(NDUT); d++)
        check($sformatf("stale_valid_d%0d", d), 64'(ov[d]), 64'd0);
    end

    // Pipe still works after reset
    for (int i = 0; i < 6; i++) rand_op(1'b1, "post_rst_op", 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/arm_shift_pipe.md
Name: arm_shift_pipe

Overview:
Parametrised, pipelined successor to the combinational ARM barrel shifter. Executes LSL/LSR/ASR/ROR with ARM carry-out semantics for both immediate-encoded and register-specified shift amounts (register amounts up to 2^AMOUNT_WIDTH-1, including amount ≥ DATA_WIDTH). Shift ranks are split across STAGES register stages with a valid/ready handshake. Sits between operand fetch and the ALU in the execute path.

Parameters:
DATA_WIDTH, 32, operand width; power of two, ≥ 8
AMOUNT_WIDTH, 8, width of shift_amount (register mode uses all bits)
STAGES, 2, pipeline register stages, 1..log2(DATA_WIDTH); ranks distributed evenly, earlier stages take any remainder

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand valid
in_ready  out  1  shifter can accept operand this cycle
imm_mode  in  1  1 = immediate encoding, 0 = register-specified amount
shift_op  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
shift_in  in  DATA_WIDTH  operand
shift_amount  in  AMOUNT_WIDTH  shift count
carry_in  in  1  current C flag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
shift_out  out  DATA_WIDTH  shifted result
carry_out  out  1  shifter carry out

Behaviour:
- Reset (rst_n low, async): all stage valid bits 0, out_valid 0, shift_out 0, carry_out 0. in_ready 1 once reset deasserts. An in-flight operation is discarded on reset.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Pipeline stall: stall = out_valid & ~out_ready. When stall is set, every stage holds. in_ready = ~stall. Otherwise all stages advance each cycle, and bubbles propagate as valid=0.
- Latency: exactly STAGES cycles from input transfer to out_valid with no stall. Throughput: 1 operation per cycle.
- Result is captured into the output register only on advance. shift_out and carry_out hold stable while out_valid & ~out_ready.
- Let W = DATA_WIDTH, A = amount, L = log2(W), and a = A[L-1:0].
- Immediate mode (imm_mode = 1): bits above L-1 are ignored; A = a.
  - LSL#0: out = in, C = carry_in.
  - LSR#0 means LSR#W: out = 0, C = in[W-1].
  - ASR#0 means ASR#W: out = {W{in[W-1]}}, C = in[W-1].
  - ROR#0 means RRX: out = {carry_in, in[W-1:1]}, C = in[0].
  - Nonzero a: normal shift.
- Register mode (imm_mode = 0): full A is used.
  - A = 0, any op: out = in, C = carry_in.
  - LSL, 1 ≤ A < W: normal; C = in[W-A].
  - LSL, A = W: out = 0, C = in[0]. A > W: out = 0, C = 0.
  - LSR, 1 ≤ A < W: normal; C = in[A-1]. A = W: out = 0, C = in[W-1]. A > W: out = 0, C = 0.
  - ASR, A ≥ W: out = {W{in[W-1]}}, C = in[W-1].
  - ROR, A ≠ 0 and a = 0: out = in, C = in[W-1]. Otherwise rotate right by a, C = out[W-1].
- Special-case decode (zero/≥W/RRX) is done in stage 0 and carried down the pipe as control bits. Sign and carry bits are carried alongside the data (W+1 bit datapath).
- Inputs sampled while in_ready = 0 are ignored. in_valid may drop at any time without effect.

Test Plan:
- Reset mid-stream: load 3 ops, assert rst_n = 0 → out_valid = 0, shift_out = 0, carry_out = 0 immediately. After release, no stale result appears.
- Immediate mode, W = 32, in = 0x8000_0001, C = 0:
  - LSR#0 → 0x0000_0000, C = 1.
  - ASR#0 → 0xFFFF_FFFF, C = 1.
  - ROR#0 → 0x4000_0000, C = 1.
  - LSL#0 → 0x8000_0001, C = 0.
- Register mode, in = 0x8000_0001:
  - LSL 32 → 0, C = 1.
  - LSL 33 → 0, C = 0.
  - LSR 200 → 0, C = 0.
  - ASR 255 → 0xFFFF_FFFF, C = 1.
  - ROR 64 → 0x8000_0001, C = 1.
  - ROR 36 → 0x1800_0000, C = 0.
  - LSL 0 with carry_in = 1 → unchanged, C = 1.
- Back-to-back: 16 random ops with out_ready = 1 → results in order, first at cycle STAGES, one per cycle, all matching the reference model.
- Backpressure: out_ready = 0 for 5 cycles with a full pipe → in_ready = 0, outputs stable. After release, no loss or duplication, order preserved.
- Parameter sweep: DATA_WIDTH = 8/16/64 and STAGES = 1..L with random ops → matches model. Latency = STAGES.
